// File: rtl/fifo_arbiter.sv
// Round-robin arbiter that moves words from four input FIFOs to four output FIFOs.
// Each word is routed by its top two bits, and the block also owns the shared FIFO threshold configuration.
module fifo_arbiter #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              init,
    input  logic [4:0]        umbral_empty_in,
    input  logic [4:0]        umbral_full_in,
    input  logic [3:0]        fifo_empty_in,
    input  logic [3:0]        valid_in,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [3:0]        pause_in,
    input  logic [7:0]        err_in,
    output logic [3:0]        fifo_rd_out,
    output logic [3:0]        fifo_wr_out,
    output logic [DATA_W-1:0] data_out,
    output logic [4:0]        al_empty_out,
    output logic [4:0]        al_full_out,
    output logic [2:0]        state,
    output logic              idle,
    output logic              err_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3
    } state_t;

    state_t            st;
    logic [1:0]        rr_ptr;
    logic [1:0]        grant_idx;
    logic [1:0]        cand;
    logic              grant_vld;
    logic              issue;
    logic              vld_p0;
    logic              vld_p1;
    logic [1:0]        sel_p0;
    logic [1:0]        sel_p1;
    logic [DATA_W-1:0] word_p1;

    function automatic logic [3:0] dest_strobe(input logic [1:0] idx);
        dest_strobe = 4'b0001 << idx;
    endfunction

    assign state  = st;
    assign vld_p0 = |fifo_rd_out;

    // Scan downward from the farthest candidate so the nearest non-empty FIFO after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (!fifo_empty_in[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign issue = (st == ST_ACTIVE) && (pause_in == 4'b0000) && grant_vld;

    always_comb begin
        case (sel_p1)
            2'd0:    word_p1 = data_in0;
            2'd1:    word_p1 = data_in1;
            2'd2:    word_p1 = data_in2;
            default: word_p1 = data_in3;
        endcase
    end

    // p0 -> p1: carry the granted FIFO index alongside its read strobe.
    always_ff @(posedge clk) begin
        if (issue)
            sel_p0 <= grant_idx;
        sel_p1 <= sel_p0;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            st           <= ST_RESET;
            rr_ptr       <= 2'd0;
            vld_p1       <= 1'b0;
            fifo_rd_out  <= 4'b0000;
            fifo_wr_out  <= 4'b0000;
            data_out     <= '0;
            al_empty_out <= 5'd1;
            al_full_out  <= 5'd6;
            idle         <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            fifo_rd_out <= issue ? dest_strobe(grant_idx) : 4'b0000;
            if (issue)
                rr_ptr <= grant_idx + 2'd1;
            vld_p1      <= vld_p0;
            fifo_wr_out <= 4'b0000;

            // p1 -> p2: forward the sampled word, or flag a read that returned nothing.
            if (vld_p1) begin
                if (valid_in[sel_p1]) begin
                    data_out    <= word_p1;
                    fifo_wr_out <= dest_strobe(word_p1[DATA_W-1:DATA_W-2]);
                end else begin
                    err_out <= 1'b1;
                end
            end
            if (|err_in)
                err_out <= 1'b1;

            case (st)
                ST_RESET: begin
                    st   <= ST_INIT;
                    idle <= 1'b0;
                end
                ST_INIT: begin
                    if (init) begin
                        if (umbral_full_in > umbral_empty_in) begin
                            al_empty_out <= umbral_empty_in;
                            al_full_out  <= umbral_full_in;
                        end
                        idle <= 1'b0;
                    end else begin
                        st   <= ST_IDLE;
                        idle <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        st   <= ST_INIT;
                        idle <= 1'b0;
                    end else if (!(&fifo_empty_in) && (pause_in == 4'b0000)) begin
                        st   <= ST_ACTIVE;
                        idle <= 1'b0;
                    end else begin
                        idle <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // Leave only once nothing is left to read and no read is still in the pipe.
                    if ((&fifo_empty_in) && !vld_p0 && !vld_p1) begin
                        st   <= ST_IDLE;
                        idle <= 1'b1;
                    end else begin
                        idle <= 1'b0;
                    end
                end
                default: begin
                    st   <= ST_RESET;
                    idle <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: models the four input FIFOs and checks every routed word through a scoreboard.
// Grant order is checked against an independent round-robin model.
module tb_fifo_arbiter;

    logic       clk = 1'b0;
    logic       RESET;
    logic       init;
    logic [4:0] umbral_empty_in;
    logic [4:0] umbral_full_in;
    logic [3:0] fifo_empty_in;
    logic [3:0] valid_in;
    logic [5:0] din [4];
    logic [3:0] pause_in;
    logic [7:0] err_in;
    logic [3:0] fifo_rd_out;
    logic [3:0] fifo_wr_out;
    logic [5:0] data_out;
    logic [4:0] al_empty_out;
    logic [4:0] al_full_out;
    logic [2:0] state;
    logic       idle;
    logic       err_out;

    fifo_arbiter #(.DATA_W(6)) dut (
        .clk(clk), .RESET(RESET), .init(init),
        .umbral_empty_in(umbral_empty_in), .umbral_full_in(umbral_full_in),
        .fifo_empty_in(fifo_empty_in), .valid_in(valid_in),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .pause_in(pause_in), .err_in(err_in),
        .fifo_rd_out(fifo_rd_out), .fifo_wr_out(fifo_wr_out), .data_out(data_out),
        .al_empty_out(al_empty_out), .al_full_out(al_full_out),
        .state(state), .idle(idle), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] word;
        int         due;
    } sb_t;

    sb_t        sb[$];
    logic [5:0] mem [4][16];
    int         head [4];
    int         cnt [4];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cycle = 0;
    int         wr_count = 0;
    int         first_rd_cycle = -1;
    int         first_wr_cycle = -1;
    logic [3:0] gl_log[$];
    int         gc_log[$];
    logic [1:0] rr_model = 2'd0;
    logic [3:0] pause_prev = 4'b0;
    logic [3:0] empty_prev = 4'hF;
    logic       pend_vld = 1'b0;
    logic [1:0] pend_g = 2'd0;
    logic [5:0] pend_word = 6'd0;
    logic       drop_valid = 1'b0;
    logic [3:0] last_wr = 4'b0;
    logic [5:0] last_data = 6'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] emp);
        logic [1:0] c;
        rr_pick = ptr;
        for (int k = 0; k < 4; k++) begin
            c = ptr + 2'(k);
            if (!emp[c]) begin
                rr_pick = c;
                break;
            end
        end
    endfunction

    function automatic bit busy();
        busy = pend_vld || (sb.size() != 0);
        for (int i = 0; i < 4; i++)
            if (cnt[i] != 0) busy = 1'b1;
    endfunction

    task automatic load(input int f, input logic [5:0] w);
        mem[f][(head[f] + cnt[f]) % 16] = w;
        cnt[f]++;
        fifo_empty_in[f] = 1'b0;
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        fifo_empty_in = 4'hF;
        valid_in      = 4'b0;
        for (int i = 0; i < 4; i++) din[i] = 6'd0;
        pend_vld = 1'b0;
        rr_model = 2'd0;
    endtask

    task automatic clear_logs();
        gl_log.delete();
        gc_log.delete();
        first_rd_cycle = -1;
        first_wr_cycle = -1;
    endtask

    task automatic tick();
        sb_t        e;
        logic [1:0] g;
        int         a;
        pause_prev = pause_in;
        empty_prev = fifo_empty_in;
        @(posedge clk);
        #1;
        cycle++;
        if (fifo_wr_out != 4'b0) begin
            wr_count++;
            last_wr   = fifo_wr_out;
            last_data = data_out;
            if (first_wr_cycle < 0) first_wr_cycle = cycle;
            if (sb.size() == 0) begin
                check_eq("unexpected_wr", 32'(fifo_wr_out), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("wr_cycle", 32'(cycle), 32'(e.due));
                check_eq("data_out", 32'(data_out), 32'(e.word));
                check_eq("wr_strobe", 32'(fifo_wr_out), 32'(4'b0001 << e.word[5:4]));
            end
        end else if (sb.size() != 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            check_eq("missing_wr", 32'(fifo_wr_out), 32'(4'b0001 << e.word[5:4]));
        end
        valid_in = 4'b0;
        for (int i = 0; i < 4; i++) din[i] = 6'd0;
        if (pend_vld) begin
            din[pend_g]      = pend_word;
            valid_in[pend_g] = !drop_valid;
            if (!drop_valid) sb.push_back('{pend_word, cycle + 1});
            pend_vld = 1'b0;
        end
        if (fifo_rd_out != 4'b0) begin
            check_eq("rd_onehot", 32'($onehot(fifo_rd_out)), 32'd1);
            check_eq("rd_while_paused", 32'(pause_prev), 32'd0);
            g = rr_pick(rr_model, empty_prev);
            check_eq("rd_grant", 32'(fifo_rd_out), 32'(4'b0001 << g));
            rr_model = g + 2'd1;
            gl_log.push_back(fifo_rd_out);
            gc_log.push_back(cycle);
            if (first_rd_cycle < 0) first_rd_cycle = cycle;
            a = 0;
            for (int i = 0; i < 4; i++) if (fifo_rd_out[i]) a = i;
            if (cnt[a] == 0) begin
                check_eq("rd_from_empty", 32'(a), 32'hFF);
            end else begin
                pend_word = mem[a][head[a]];
                pend_g    = 2'(a);
                pend_vld  = 1'b1;
                head[a]   = (head[a] + 1) % 16;
                cnt[a]--;
            end
        end
        for (int i = 0; i < 4; i++) fifo_empty_in[i] = (cnt[i] == 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(busy()), 32'd0);
        tick();
        tick();
        check_eq({tag, "_idle_state"}, 32'(state), 32'd2);
        check_eq({tag, "_idle_flag"}, 32'(idle), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, 32'(state), 32'd0);
        check_eq({tag, "_rd"}, 32'(fifo_rd_out), 32'd0);
        check_eq({tag, "_wr"}, 32'(fifo_wr_out), 32'd0);
        check_eq({tag, "_data"}, 32'(data_out), 32'd0);
        check_eq({tag, "_al_empty"}, 32'(al_empty_out), 32'd1);
        check_eq({tag, "_al_full"}, 32'(al_full_out), 32'd6);
        check_eq({tag, "_idle"}, 32'(idle), 32'd0);
        check_eq({tag, "_err"}, 32'(err_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        RESET = 1'b1;
        init = 1'b0;
        umbral_empty_in = 5'd0;
        umbral_full_in = 5'd0;
        pause_in = 4'b0;
        err_in = 8'b0;
        clear_model();
        tick();
        tick();
        check_reset_outputs("reset");

        // Invalid configuration is rejected.
        init = 1'b1;
        umbral_empty_in = 5'd7;
        umbral_full_in = 5'd4;
        RESET = 1'b0;
        tick();
        check_eq("to_init_state", 32'(state), 32'd1);
        tick();
        check_eq("bad_cfg_empty", 32'(al_empty_out), 32'd1);
        check_eq("bad_cfg_full", 32'(al_full_out), 32'd6);
        init = 1'b0;
        tick();
        check_eq("init_to_idle", 32'(state), 32'd2);
        check_eq("idle_flag", 32'(idle), 32'd1);

        // Valid configuration via IDLE -> INIT.
        init = 1'b1;
        umbral_empty_in = 5'd2;
        umbral_full_in = 5'd5;
        tick();
        check_eq("idle_to_init", 32'(state), 32'd1);
        check_eq("idle_flag_init", 32'(idle), 32'd0);
        tick();
        check_eq("cfg_empty", 32'(al_empty_out), 32'd2);
        check_eq("cfg_full", 32'(al_full_out), 32'd5);
        init = 1'b0;
        tick();
        check_eq("cfg_back_idle", 32'(state), 32'd2);

        // Round robin over four loaded FIFOs.
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int f = 0; f < 4; f++)
                load(f, 6'($urandom_range(0, 63)));
        drain("rr", 60);
        check_eq("rr_grant_count", 32'(gl_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < gl_log.size(); i++)
            check_eq("rr_sequence", 32'(gl_log[i]), 32'(4'b0001 << (i % 4)));
        check_eq("rr_first_latency", 32'(first_wr_cycle - first_rd_cycle), 32'd2);

        // Only FIFO 2 holds data: consecutive grants to it.
        clear_logs();
        for (int r = 0; r < 3; r++) load(2, 6'($urandom_range(0, 63)));
        drain("solo", 40);
        check_eq("solo_count", 32'(gl_log.size()), 32'd3);
        for (int i = 1; i < gl_log.size(); i++) begin
            check_eq("solo_grant", 32'(gl_log[i]), 32'b0100);
            check_eq("solo_back_to_back", 32'(gc_log[i] - gc_log[i-1]), 32'd1);
        end

        // Routing of one word from FIFO 1.
        clear_logs();
        load(1, 6'b10_0101);
        drain("route", 30);
        check_eq("route_rd", 32'((gl_log.size() > 0) ? gl_log[0] : 4'b0), 32'b0010);
        check_eq("route_data", 32'(last_data), 32'b100101);
        check_eq("route_wr", 32'(last_wr), 32'b0100);
        check_eq("route_latency", 32'(first_wr_cycle - first_rd_cycle), 32'd2);

        // Pause mid-burst; init is ignored while ACTIVE.
        clear_logs();
        for (int r = 0; r < 3; r++)
            for (int f = 0; f < 4; f++)
                load(f, 6'($urandom_range(0, 63)));
        n = 0;
        while (gl_log.size() < 2 && n < 30) begin
            tick();
            n++;
        end
        check_eq("pause_burst_started", 32'(gl_log.size() >= 2), 32'd1);
        pause_in = 4'b0010;
        init = 1'b1;
        umbral_empty_in = 5'd3;
        umbral_full_in = 5'd9;
        tick();
        check_eq("pause_rd_stop", 32'(fifo_rd_out), 32'd0);
        base = gl_log.size();
        for (int i = 0; i < 4; i++) tick();
        check_eq("pause_no_new_rd", 32'(gl_log.size()), 32'(base));
        check_eq("pause_inflight_done", 32'(sb.size() + int'(pend_vld)), 32'd0);
        check_eq("init_ignored_state", 32'(state), 32'd3);
        check_eq("init_ignored_empty", 32'(al_empty_out), 32'd2);
        check_eq("init_ignored_full", 32'(al_full_out), 32'd5);
        init = 1'b0;
        pause_in = 4'b0000;
        drain("pause", 80);
        check_eq("pause_total_grants", 32'(gl_log.size()), 32'd12);

        // Sticky error from err_in.
        check_eq("err_clear", 32'(err_out), 32'd0);
        err_in = 8'h20;
        tick();
        err_in = 8'h00;
        check_eq("err_set", 32'(err_out), 32'd1);
        tick();
        tick();
        check_eq("err_sticky", 32'(err_out), 32'd1);

        // Reset in the middle of a burst.
        clear_logs();
        for (int r = 0; r < 3; r++)
            for (int f = 0; f < 4; f++)
                load(f, 6'($urandom_range(0, 63)));
        n = 0;
        while (gl_log.size() < 1 && n < 30) begin
            tick();
            n++;
        end
        tick();
        check_eq("mid_rst_active", 32'(state), 32'd3);
        RESET = 1'b1;
        clear_model();
        tick();
        check_reset_outputs("mid_rst");
        RESET = 1'b0;
        base = wr_count;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mid_rst_no_wr", 32'(fifo_wr_out), 32'd0);
        end
        check_eq("mid_rst_wr_count", 32'(wr_count), 32'(base));
        check_eq("mid_rst_idle", 32'(state), 32'd2);

        // A read that returns no valid word raises err and writes nothing.
        drop_valid = 1'b1;
        base = wr_count;
        load(0, 6'b01_0011);
        drain("drop", 30);
        drop_valid = 1'b0;
        check_eq("drop_err", 32'(err_out), 32'd1);
        check_eq("drop_no_wr", 32'(wr_count), 32'(base));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
